// File: rtl/game_countdown_timer_if.sv
// -----------------------------------------------------------------------------
// game_countdown_timer_if
//   Groups the control pulses and status outputs of the claw-game round timer.
//
//   Signals
//     start       controller -> timer  1-cycle pulse, begin a round from IDLE/OVER
//     pause       controller -> timer  1-cycle pulse, toggle RUNNING <-> PAUSED
//     add_time    controller -> timer  1-cycle pulse, bonus-time request
//     time_left   timer -> controller  remaining seconds
//     game_active timer -> controller  high only while RUNNING
//     game_over   timer -> controller  1-cycle pulse when time_left first reads 0
//     sec_tick    timer -> controller  1-cycle pulse on each counted second
//     state       timer -> controller  IDLE=00, RUNNING=01, PAUSED=10, OVER=11
//
//   Modports
//     master  drives the requests, observes the status (game logic / bench)
//     slave   the timer itself
// -----------------------------------------------------------------------------
interface game_countdown_timer_if #(
  parameter int TIME_W = 16
);
  logic              start;
  logic              pause;
  logic              add_time;
  logic [TIME_W-1:0] time_left;
  logic              game_active;
  logic              game_over;
  logic              sec_tick;
  logic [1:0]        state;

  modport master (
    output start, pause, add_time,
    input  time_left, game_active, game_over, sec_tick, state
  );

  modport slave (
    input  start, pause, add_time,
    output time_left, game_active, game_over, sec_tick, state
  );
endinterface

// File: rtl/game_countdown_timer.sv
// -----------------------------------------------------------------------------
// game_countdown_timer
//   Round timer for the claw game. Divides the system clock down to a 1 s tick
//   and counts the round time down from GAME_SECONDS, with start, pause/resume
//   and saturating bonus time. Feeds the LED display (time_left) and the score
//   gate (game_active, game_over).
//
//   Ports
//     clock   in     system clock, rising edge
//     reset   in     synchronous active-high reset, overrides all other inputs
//     gif     slave  control pulses in, status out (see game_countdown_timer_if)
//
//   Parameters
//     CLK_HZ         clock cycles per counted second
//     GAME_SECONDS   round length loaded on start (>= 1)
//     BONUS_SECONDS  seconds added per add_time pulse
//     MAX_SECONDS    saturation ceiling for time_left (< 2**TIME_W)
//     TIME_W         width of time_left; must match the interface instance
// -----------------------------------------------------------------------------
module game_countdown_timer #(
  parameter int CLK_HZ        = 100_000_000,
  parameter int GAME_SECONDS  = 60,
  parameter int BONUS_SECONDS = 5,
  parameter int MAX_SECONDS   = 999,
  parameter int TIME_W        = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  game_countdown_timer_if.slave  gif
);

  // ---------------------------------------------------------------------------
  // Parameter sanity: refuse to elaborate a timer that could never work.
  // ---------------------------------------------------------------------------
  if (CLK_HZ < 1) begin : g_bad_clk_hz
    $error("game_countdown_timer: CLK_HZ must be >= 1");
  end
  if (GAME_SECONDS < 1) begin : g_bad_game_seconds
    $error("game_countdown_timer: GAME_SECONDS must be >= 1");
  end
  if (GAME_SECONDS > MAX_SECONDS) begin : g_bad_max_vs_game
    $error("game_countdown_timer: GAME_SECONDS must not exceed MAX_SECONDS");
  end
  if ((64'(MAX_SECONDS) >> TIME_W) != 64'd0) begin : g_bad_time_w
    $error("game_countdown_timer: MAX_SECONDS must fit in TIME_W bits");
  end

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]     PRESC_LAST = PW'(CLK_HZ - 1);
  localparam logic [TIME_W-1:0] TIME_GAME  = TIME_W'(GAME_SECONDS);
  localparam logic [TIME_W-1:0] TIME_MAX   = TIME_W'(MAX_SECONDS);
  localparam logic [TIME_W:0]   BONUS_EXT  = (TIME_W+1)'(BONUS_SECONDS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUNNING = 2'b01,
    ST_PAUSED  = 2'b10,
    ST_OVER    = 2'b11
  } state_t;

  state_t            r_state;
  logic [PW-1:0]     r_prescaler;
  logic [TIME_W-1:0] r_time_left;
  logic              r_sec_tick;
  logic              r_game_over;

  state_t            w_state_nxt;
  logic [PW-1:0]     w_prescaler_nxt;
  logic [TIME_W-1:0] w_time_left_nxt;
  logic [TIME_W-1:0] w_time_base;
  logic              w_sec_tick_nxt;
  logic              w_game_over_nxt;
  logic              w_wrap;

  // Bonus add with one guard bit so a sum past 2**TIME_W-1 still saturates
  // instead of wrapping to a small value.
  function automatic logic [TIME_W-1:0] add_bonus(input logic [TIME_W-1:0] t);
    logic [TIME_W:0] sum;
    sum = {1'b0, t} + BONUS_EXT;
    return (sum > {1'b0, TIME_MAX}) ? TIME_MAX : sum[TIME_W-1:0];
  endfunction

  assign w_wrap = (r_prescaler == PRESC_LAST);

  // ---------------------------------------------------------------------------
  // Next-state and next-value logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can leave
    // it unassigned, which would otherwise infer a latch.
    w_state_nxt     = r_state;
    w_prescaler_nxt = r_prescaler;
    w_time_left_nxt = r_time_left;
    w_time_base     = r_time_left;
    w_sec_tick_nxt  = 1'b0;
    w_game_over_nxt = 1'b0;

    unique case (r_state)
      ST_IDLE, ST_OVER: begin
        // start outranks pause; add_time has no effect outside a round.
        if (gif.start) begin
          w_state_nxt     = ST_RUNNING;
          w_time_left_nxt = TIME_GAME;
          w_prescaler_nxt = '0;
        end
      end

      ST_RUNNING: begin
        if (w_wrap) begin
          w_prescaler_nxt = '0;
          w_sec_tick_nxt  = 1'b1;
          if (r_time_left != '0) begin
            w_time_base = r_time_left - TIME_W'(1);
          end
        end else begin
          w_prescaler_nxt = r_prescaler + PW'(1);
        end

        // The second that ends on the pause edge is still counted.
        if (gif.pause) begin
          w_state_nxt = ST_PAUSED;
        end

        // Bonus time landing on the final tick rescues the round.
        if (gif.add_time) begin
          w_time_left_nxt = add_bonus(w_time_base);
        end else begin
          w_time_left_nxt = w_time_base;
          if (w_wrap && (r_time_left == TIME_W'(1))) begin
            w_state_nxt     = ST_OVER;
            w_game_over_nxt = 1'b1;
          end
        end
      end

      ST_PAUSED: begin
        // Prescaler holds so the partial second resumes where it stopped.
        if (gif.add_time) begin
          w_time_left_nxt = add_bonus(r_time_left);
        end
        if (gif.pause) begin
          w_state_nxt = ST_RUNNING;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order.
    if (reset) begin
      r_state     <= ST_IDLE;
      r_prescaler <= '0;
      r_time_left <= TIME_GAME;
      r_sec_tick  <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_prescaler <= w_prescaler_nxt;
      r_time_left <= w_time_left_nxt;
      r_sec_tick  <= w_sec_tick_nxt;
      r_game_over <= w_game_over_nxt;
    end
  end

  assign gif.time_left   = r_time_left;
  assign gif.state       = r_state;
  assign gif.game_active = (r_state == ST_RUNNING);
  assign gif.sec_tick    = r_sec_tick;
  assign gif.game_over   = r_game_over;

endmodule

// File: tb/tb_game_countdown_timer.sv
// -----------------------------------------------------------------------------
// tb_game_countdown_timer
//   Directed bench for game_countdown_timer with CLK_HZ=4, GAME_SECONDS=3,
//   BONUS_SECONDS=2, MAX_SECONDS=4. Inputs change and outputs are sampled on
//   the falling edge; each step() advances exactly one rising edge.
// -----------------------------------------------------------------------------
module tb_game_countdown_timer;

  localparam int CLK_HZ        = 4;
  localparam int GAME_SECONDS  = 3;
  localparam int BONUS_SECONDS = 2;
  localparam int MAX_SECONDS   = 4;
  localparam int TIME_W        = 16;

  localparam int ST_IDLE    = 0;
  localparam int ST_RUNNING = 1;
  localparam int ST_PAUSED  = 2;
  localparam int ST_OVER    = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  game_countdown_timer_if #(.TIME_W(TIME_W)) gif ();

  game_countdown_timer #(
    .CLK_HZ       (CLK_HZ),
    .GAME_SECONDS (GAME_SECONDS),
    .BONUS_SECONDS(BONUS_SECONDS),
    .MAX_SECONDS  (MAX_SECONDS),
    .TIME_W       (TIME_W)
  ) u_dut (
    .clock(clock),
    .reset(reset),
    .gif  (gif.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic expect_out(input string tag, input int st, input int tl,
                            input int tick, input int over);
    check({tag, ".state"},  32'(gif.state),       32'(st));
    check({tag, ".time"},   32'(gif.time_left),   32'(tl));
    check({tag, ".tick"},   32'(gif.sec_tick),    32'(tick));
    check({tag, ".over"},   32'(gif.game_over),   32'(over));
    check({tag, ".active"}, 32'(gif.game_active), (st == ST_RUNNING) ? 32'd1 : 32'd0);
  endtask

  task automatic do_reset();
    gif.start    = 1'b0;
    gif.pause    = 1'b0;
    gif.add_time = 1'b0;
    reset        = 1'b1;
    step(2);
    reset        = 1'b0;
  endtask

  task automatic pulse_start();
    gif.start = 1'b1;
    step(1);
    gif.start = 1'b0;
  endtask

  initial begin
    gif.start    = 1'b0;
    gif.pause    = 1'b0;
    gif.add_time = 1'b0;
    step(2);
    reset = 1'b0;
    expect_out("reset", ST_IDLE, 3, 0, 0);

    // 1: full round, ticks at 4, 8, 12 cycles after the start edge
    pulse_start();
    expect_out("s1.start", ST_RUNNING, 3, 0, 0);
    for (int k = 1; k <= 12; k++) begin
      step(1);
      expect_out($sformatf("s1.c%0d", k), (k < 12) ? ST_RUNNING : ST_OVER,
                 3 - k / 4, (k % 4 == 0) ? 1 : 0, (k == 12) ? 1 : 0);
    end
    step(1);
    expect_out("s1.after", ST_OVER, 0, 0, 0);

    // 6: restart from OVER; start while RUNNING leaves the countdown alone
    pulse_start();
    expect_out("s6.restart", ST_RUNNING, 3, 0, 0);
    step(2);
    pulse_start();
    expect_out("s6.ign_start", ST_RUNNING, 3, 0, 0);
    step(1);
    expect_out("s6.tick", ST_RUNNING, 2, 1, 0);

    // 2: pause two cycles into the round, hold, resume
    do_reset();
    pulse_start();
    step(1);
    gif.pause = 1'b1;
    step(1);
    gif.pause = 1'b0;
    expect_out("s2.paused", ST_PAUSED, 3, 0, 0);
    for (int k = 0; k < 10; k++) begin
      step(1);
      expect_out($sformatf("s2.hold%0d", k), ST_PAUSED, 3, 0, 0);
    end
    gif.pause = 1'b1;
    step(1);
    gif.pause = 1'b0;
    expect_out("s2.resume", ST_RUNNING, 3, 0, 0);
    step(1);
    expect_out("s2.r1", ST_RUNNING, 3, 0, 0);
    step(1);
    expect_out("s2.r2", ST_RUNNING, 2, 1, 0);

    // 3: add_time ignored in IDLE; start+pause in IDLE -> start wins; saturation
    do_reset();
    gif.add_time = 1'b1;
    step(1);
    gif.add_time = 1'b0;
    expect_out("s3.idle_add", ST_IDLE, 3, 0, 0);
    gif.start = 1'b1;
    gif.pause = 1'b1;
    step(1);
    gif.start = 1'b0;
    gif.pause = 1'b0;
    expect_out("s3.start_pause", ST_RUNNING, 3, 0, 0);
    gif.add_time = 1'b1;
    step(1);
    gif.add_time = 1'b0;
    expect_out("s3.sat", ST_RUNNING, 4, 0, 0);

    // 4: bonus on the tick that would expire the round
    do_reset();
    pulse_start();
    step(11);
    expect_out("s4.pre", ST_RUNNING, 1, 0, 0);
    gif.add_time = 1'b1;
    step(1);
    gif.add_time = 1'b0;
    expect_out("s4.rescue", ST_RUNNING, 2, 1, 0);
    step(1);
    expect_out("s4.after", ST_RUNNING, 2, 0, 0);

    // pause on the wrap edge: second is counted, then PAUSED
    do_reset();
    pulse_start();
    step(3);
    gif.pause = 1'b1;
    step(1);
    gif.pause = 1'b0;
    expect_out("pw.edge", ST_PAUSED, 2, 1, 0);
    step(1);
    expect_out("pw.hold", ST_PAUSED, 2, 0, 0);

    // 5: reset with start on what would be a tick edge
    do_reset();
    pulse_start();
    step(3);
    reset     = 1'b1;
    gif.start = 1'b1;
    step(1);
    reset     = 1'b0;
    gif.start = 1'b0;
    expect_out("s5.reset", ST_IDLE, 3, 0, 0);
    step(1);
    expect_out("s5.idle", ST_IDLE, 3, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
